// File: rtl/iram_ctrl.sv
// Instruction-RAM controller.
// On a cache miss the whole line holding the requested word is read from an
// internal word-wide memory and returned one word per cycle after a fixed
// latency. A program-load port fills the memory while the controller is idle.
//
// Handshake: i_miss is a level request held by the core until the line is
// served; each word is presented for exactly one cycle with word_ready=1 and
// there is no back-pressure. Dropping i_miss before the line completes
// abandons the request; dropping it after the line is served releases the
// controller back to IDLE.
module iram_ctrl #(
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          i_miss,
  input  logic [PC_SIZE-1:0]            ram_address,
  output logic [WORD_SIZE-1:0]          mem_word,
  output logic                          word_ready,
  output logic [$clog2(LINE_WORDS)-1:0] word_offset,
  output logic                          busy,
  input  logic                          prog_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  prog_addr,
  input  logic [WORD_SIZE-1:0]          prog_data
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int LW = AW - OW;  // width of a line index
  localparam int CW = (LATENCY >= 2) ? $clog2(LATENCY) : 1;

  // The WAIT countdown starts at LATENCY-2 so that the first word is
  // registered on the edge ending cycle T+LATENCY-1 and is visible in
  // cycle T+LATENCY.
  localparam int              LAT_LOAD_I = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam logic [CW-1:0]   LAT_LOAD   = CW'(LAT_LOAD_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_RELEASE
  } state_t;

  // State register kept under a stable name so it can be probed from outside.
  state_t state_q;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

  logic [LW-1:0] line_q;   // line index of the request being served
  logic [OW-1:0] off_q;    // offset of the next word to issue
  logic [CW-1:0] cnt_q;    // remaining WAIT cycles before the first word

  logic [LW-1:0]        miss_line;
  logic [AW-1:0]        rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 mem_wr;
  logic                 addr_unused;

  // Only the word-index bits select memory; byte bits and upper bits are
  // deliberately dropped so addresses wrap modulo the memory size.
  assign miss_line   = ram_address[2+OW +: LW];
  assign addr_unused = ^ram_address;

  // Writes land only while idle and out of reset.
  assign mem_wr = nrst && prog_we && (state_q == S_IDLE);

  assign busy = (state_q != S_IDLE);

  // Read port: in IDLE the first word of the incoming line is addressed,
  // otherwise the next word of the latched line. A write in the same IDLE
  // edge is forwarded so the burst sees the freshly loaded word.
  always_comb begin
    rd_addr = {line_q, off_q};
    if (state_q == S_IDLE) begin
      rd_addr = {miss_line, {OW{1'b0}}};
    end
    rd_data = mem[rd_addr];
    if (mem_wr && (prog_addr == rd_addr)) begin
      rd_data = prog_data;
    end
  end

  // Program-load write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Miss-handling FSM with registered word outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      mem_word    <= '0;
      word_ready  <= 1'b0;
      word_offset <= '0;
      line_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          word_ready <= 1'b0;
          if (i_miss) begin
            line_q <= miss_line;
            if (LATENCY == 1) begin
              // No waiting: the first word leaves on the accepting edge.
              mem_word    <= rd_data;
              word_ready  <= 1'b1;
              word_offset <= '0;
              off_q       <= OW'(1);
              state_q     <= S_BURST;
            end else begin
              cnt_q   <= LAT_LOAD;
              off_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          word_ready <= 1'b0;
          if (!i_miss) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            mem_word    <= rd_data;
            word_ready  <= 1'b1;
            word_offset <= off_q;
            off_q       <= off_q + OW'(1);
            state_q     <= S_BURST;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_BURST: begin
          if (!i_miss) begin
            word_ready <= 1'b0;
            state_q    <= S_IDLE;
          end else if (&word_offset) begin
            // Last word of the line was on the bus this cycle.
            word_ready <= 1'b0;
            state_q    <= S_RELEASE;
          end else begin
            mem_word    <= rd_data;
            word_ready  <= 1'b1;
            word_offset <= off_q;
            off_q       <= off_q + OW'(1);
          end
        end

        S_RELEASE: begin
          word_ready <= 1'b0;
          if (!i_miss) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          word_ready <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_ctrl.sv
// Bench for iram_ctrl: directed misses with a scoreboard of expected
// {cycle, offset, word} entries checked by an independent monitor.
module tb_iram_ctrl;

  localparam int LAT = 3;
  localparam int LWN = 4;
  localparam int EW  = 16 + 2 + 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        nrst;
  logic        i_miss;
  logic [31:0] ram_address;
  logic [31:0] mem_word;
  logic        word_ready;
  logic [1:0]  word_offset;
  logic        busy;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iram_ctrl #(
    .PC_SIZE(32), .WORD_SIZE(32), .MEM_DEPTH(1024), .LINE_WORDS(LWN), .LATENCY(LAT)
  ) dut (
    .clk(clk), .nrst(nrst), .i_miss(i_miss), .ram_address(ram_address),
    .mem_word(mem_word), .word_ready(word_ready), .word_offset(word_offset),
    .busy(busy), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [31:0]   tb_mem [0:1023];
  int checks = 0;
  int errors = 0;
  int c0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented word must match the head of the queue,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    if (word_ready === 1'b1) begin
      act = {16'(cyc), word_offset, mem_word};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got cyc/off/word %0h with nothing expected", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL word: got cyc/off/word %0h expected %0h", act, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a miss now; the line is expected LAT cycles after acceptance.
  task automatic start_miss(input logic [31:0] addr, input int nwords);
    int base;
    base = int'(addr[11:2]) & ~(LWN - 1);
    i_miss      = 1'b1;
    ram_address = addr;
    c0          = cyc;
    for (int k = 0; k < nwords; k++)
      exp_q.push_back({16'(c0 + LAT + k), 2'(k), tb_mem[base + k]});
  endtask

  // Run to the release cycle, confirm the controller holds, then release it.
  task automatic finish_miss(input string tag);
    while (cyc < c0 + LAT + LWN) tick();
    check({tag, "_release_busy"}, 64'(busy), 64'd1);
    check({tag, "_release_ready"}, 64'(word_ready), 64'd0);
    i_miss = 1'b0;
    tick();
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nrst = 1'b0; i_miss = 1'b1; ram_address = 32'h14;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Reset held for two cycles with a pending miss.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check("rst_ready", 64'(word_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_word", 64'(mem_word), 64'd0);
      check("rst_offset", 64'(word_offset), 64'd0);
    end
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd1);
    i_miss = 1'b0;  // abandon during WAIT, before any word
    @(negedge clk);
    check("wait_abort_busy", 64'(busy), 64'd0);
    check("wait_abort_ready", 64'(word_ready), 64'd0);
    tick();

    // Preload mem[k] = A000_0000 + k.
    for (int k = 0; k < 16; k++) begin
      prog_we = 1'b1; prog_addr = 10'(k); prog_data = 32'hA000_0000 + k;
      tb_mem[k] = 32'hA000_0000 + k;
      tick();
    end
    prog_we = 1'b0;
    tick();

    // Single miss, word 5 -> line 4..7.
    start_miss(32'h0000_0014, LWN);
    finish_miss("single");

    // Wrapping address: word 1026 -> line 0..3.
    start_miss(32'h0000_1008, LWN);
    finish_miss("wrap");

    // Abort after offset 1 of line 8..11.
    start_miss(32'h0000_0020, 2);
    while (cyc < c0 + LAT + 1) tick();
    i_miss = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(word_ready), 64'd0);
    start_miss(32'h0000_0030, LWN);
    finish_miss("after_abort");
    tick();

    // Reset during offset 2.
    start_miss(32'h0000_0024, 3);
    while (cyc < c0 + LAT + 2) tick();
    nrst = 1'b0; i_miss = 1'b0;
    tick();
    check("midrst_ready", 64'(word_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_word", 64'(mem_word), 64'd0);
    check("midrst_offset", 64'(word_offset), 64'd0);
    nrst = 1'b1;
    tick();
    start_miss(32'h0000_0024, LWN);
    finish_miss("after_midrst");
    tick();

    // Program write during a burst must be dropped.
    start_miss(32'h0000_0014, LWN);
    while (cyc < c0 + LAT) tick();
    prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'hDEAD_BEEF;
    tick();
    prog_we = 1'b0;
    finish_miss("burst_write");
    tick();
    start_miss(32'h0000_0014, LWN);  // mem[5] must still hold A000_0005
    finish_miss("burst_write_recheck");
    tick();

    // Write and miss on the same idle edge: burst sees the new word.
    prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'hDEAD_BEEF;
    tb_mem[5] = 32'hDEAD_BEEF;
    start_miss(32'h0000_0014, LWN);
    tick();
    prog_we = 1'b0;
    finish_miss("idle_write");

    // Drain with a bounded wait.
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/iram_ctrl.md
Name: iram_ctrl

Overview:
Instruction-RAM controller upstream of the core's fetch unit. On an instruction-cache miss it fetches the whole cache line containing the requested address from an internal instruction memory. After a fixed access latency it returns the line one word per cycle on mem_word/word_ready. A program-load port lets the bench or boot logic fill the memory while the controller is idle.

Parameters:
PC_SIZE, 32, width of ram_address (byte address).
WORD_SIZE, 32, width of one memory word (matches the core's memory_word).
MEM_DEPTH, 1024, number of words in the instruction memory; power of 2.
LINE_WORDS, 4, words per cache line; power of 2, >=2.
LATENCY, 3, cycles from miss acceptance to the first word_ready; >=1.

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  synchronous reset, active low
i_miss  in  1  cache miss request from the core, level, held until the line is served
ram_address  in  PC_SIZE  byte address of the missing instruction
mem_word  out  WORD_SIZE  returned instruction word, registered
word_ready  out  1  mem_word valid this cycle, one-cycle pulse per word
word_offset  out  log2(LINE_WORDS)  index of mem_word within the line, valid with word_ready
busy  out  1  high in any state other than IDLE
prog_we  in  1  program-load write enable
prog_addr  in  log2(MEM_DEPTH)  program-load word address
prog_data  in  WORD_SIZE  program-load data

Behaviour:
- Reset (nrst=0 at a clk edge): state IDLE; mem_word=0, word_ready=0, word_offset=0, busy=0; latency counter and offset counter cleared. Memory contents are not reset.
- Address mapping: word index = ram_address[2 +: log2(MEM_DEPTH)]. Upper bits are ignored, so addresses wrap modulo MEM_DEPTH. Line base = word index with its low log2(LINE_WORDS) bits cleared. Byte bits [1:0] are ignored.
- FSM states: IDLE, WAIT, BURST, RELEASE.
- IDLE: if i_miss=1 at edge T, latch the line base, load the latency counter, and go to WAIT. busy=1 from cycle T+1.
- WAIT: counts down. The first word is registered so that word_ready=1 in cycle T+LATENCY. For LATENCY=1, WAIT lasts zero cycles and the FSM enters BURST directly.
- BURST: in cycles T+LATENCY .. T+LATENCY+LINE_WORDS-1, word_ready=1 with mem_word=mem[base+k] and word_offset=k, k=0..LINE_WORDS-1 in order. The offset wraps within the line only; it never crosses into the next line. After the last word, go to RELEASE.
- RELEASE: word_ready=0. Stay until i_miss=0 is sampled, then go to IDLE. A new miss is accepted no earlier than the cycle after IDLE is re-entered.
- Abort: if i_miss=0 is sampled in WAIT or BURST, go to IDLE at that edge. word_ready=0 from the next cycle and no further words are issued.
- Outside BURST: word_ready=0, and mem_word holds its last value.
- Program load: if prog_we=1 and state=IDLE, mem[prog_addr]<=prog_data at the edge. prog_we is ignored in any other state.
- Simultaneous prog_we and i_miss in IDLE: the write is performed and the miss is accepted in the same edge. The burst reads the newly written data.
- Reset mid-operation: reset dominates. Next cycle is IDLE with all outputs at reset values and no residual word_ready.

Test Plan:
- Reset: hold nrst=0 for 2 cycles with i_miss=1 -> word_ready=0, busy=0, mem_word=0 throughout; after release the miss is accepted and busy rises the next cycle.
- Single miss, defaults: preload mem[k]=0xA000_0000+k; i_miss=1 with ram_address=0x0000_0014 at edge T -> word_ready in cycles T+3..T+6 with mem_word 0xA0000004..0xA0000007 and word_offset 0..3; drop i_miss at T+7 -> busy=0 at T+8.
- Address wrap: ram_address=0x0000_1008 (word 1026, wraps to 2) -> line base word 0, words mem[0..3].
- Abort: drop i_miss after the second word (offset 1) -> no word_ready in any later cycle; state IDLE; a new miss 1 cycle later is served normally.
- Reset mid-burst: assert nrst=0 during offset 2 -> next cycle word_ready=0, busy=0, mem_word=0; a following miss returns a full line starting at offset 0.
- Program load gating: prog_we with prog_addr=5, data 0xDEAD_BEEF during BURST -> mem[5] unchanged. The same write in IDLE together with i_miss to address 0x14 -> word_offset 1 returns 0xDEAD_BEEF.
